pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_if.sv | 29 ++
 rtl/pipeline_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_if.sv
// Decode-side control bundle for pipeline_ctrl. The controller consumes the
// decode flags, condition result and halt request, and drives the fetch
// enables, gated write enables and status back out.
interface pipeline_ctrl_if;
    logic [7:0]  muxflags;
    logic        cond_pass;
    logic        halt_req;
    logic        pc_we;
    logic        pc_sel;
    logic        id_valid;
    logic        reg_we;
    logic        mem_we;
    logic        link_we;
    logic        stall;
    logic [2:0]  state;
    logic [15:0] retire_cnt;

    modport slave (
        input  muxflags, cond_pass, halt_req,
        output pc_we, pc_sel, id_valid, reg_we, mem_we, link_we,
               stall, state, retire_cnt
    );

    modport master (
        output muxflags, cond_pass, halt_req,
        input  pc_we, pc_sel, id_valid, reg_we, mem_we, link_we,
               stall, state, retire_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: inserts load bubbles and branch flush
// cycles, services halt requests, gates write enables and counts issued
// instructions.
//
// state      | meaning
// -----------+---------------------------------------------------------
// FILL       | refetch after reset/halt; decode not yet valid
// RUN        | normal issue; branches, loads and halts leave from here
// LOAD_STALL | bubble cycles after an issued load, fetch frozen
// BR_FLUSH   | discard wrong-path fetches after a taken branch
// HALT       | fetch frozen until halt_req drops
module pipeline_ctrl #(
    parameter int unsigned LOAD_DELAY   = 1,
    parameter int unsigned BRANCH_FLUSH = 2
) (
    input  logic            clk,
    input  logic            reset,
    pipeline_ctrl_if.slave  pif
);

    typedef enum logic [2:0] {
        FILL       = 3'd0,
        RUN        = 3'd1,
        LOAD_STALL = 3'd2,
        BR_FLUSH   = 3'd3,
        HALT       = 3'd4
    } state_t;

    localparam logic [2:0] LOAD_CNT_INIT  = 3'(LOAD_DELAY - 1);
    localparam logic [2:0] FLUSH_CNT_INIT = 3'(BRANCH_FLUSH - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        id_valid_q, id_valid_d;
    logic [15:0] retire_q, retire_d;

    logic        issue;
    logic        pc_we, pc_sel;

    logic flag_bls, flag_bs, flag_dpf, flag_mwe, flag_rfwe;
    logic unused_flags;

    assign flag_bls     = pif.muxflags[7];
    assign flag_bs      = pif.muxflags[6];
    assign flag_dpf     = pif.muxflags[4];
    assign flag_mwe     = pif.muxflags[3];
    assign flag_rfwe    = pif.muxflags[0];
    // WBS and IS steer the datapath muxes only; bit 5 is reserved.
    assign unused_flags = ^{pif.muxflags[5], pif.muxflags[2], pif.muxflags[1]};

    assign issue = (state_q == RUN) && id_valid_q && pif.cond_pass;

    // Next-state, counter and fetch-enable decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        id_valid_d = id_valid_q;
        pc_we      = 1'b1;
        pc_sel     = 1'b0;
        unique case (state_q)
            FILL: begin
                state_d    = RUN;
                cnt_d      = 3'd0;
                id_valid_d = 1'b1;
            end
            RUN: begin
                // Branch beats load beats halt; a pending halt is picked
                // up again once the branch/load sequence returns to RUN.
                if (issue && flag_bs) begin
                    pc_sel     = 1'b1;
                    state_d    = BR_FLUSH;
                    cnt_d      = FLUSH_CNT_INIT;
                    id_valid_d = 1'b0;
                end else if (issue && flag_dpf) begin
                    pc_we      = 1'b0;
                    state_d    = LOAD_STALL;
                    cnt_d      = LOAD_CNT_INIT;
                    id_valid_d = 1'b0;
                end else if (pif.halt_req) begin
                    pc_we      = 1'b0;
                    state_d    = HALT;
                    id_valid_d = 1'b0;
                end
            end
            LOAD_STALL: begin
                pc_we      = 1'b0;
                id_valid_d = 1'b0;
                if (cnt_q == 3'd0) begin
                    state_d    = RUN;
                    id_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            BR_FLUSH: begin
                id_valid_d = 1'b0;
                if (cnt_q == 3'd0) begin
                    state_d    = RUN;
                    id_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            HALT: begin
                pc_we      = 1'b0;
                id_valid_d = 1'b0;
                if (!pif.halt_req) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d    = FILL;
                cnt_d      = 3'd0;
                id_valid_d = 1'b0;
            end
        endcase
        retire_d = retire_q + {15'd0, issue};
    end

    // Controller state registers; reset lands in FILL with nothing valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FILL;
            cnt_q      <= 3'd0;
            id_valid_q <= 1'b0;
            retire_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            id_valid_q <= id_valid_d;
            retire_q   <= retire_d;
        end
    end

    assign pif.pc_we      = pc_we;
    assign pif.pc_sel     = pc_sel;
    assign pif.id_valid   = id_valid_q;
    assign pif.reg_we     = issue & flag_rfwe;
    assign pif.mem_we     = issue & flag_mwe;
    assign pif.link_we    = issue & flag_bs & flag_bls;
    assign pif.stall      = (state_q != RUN);
    assign pif.state      = state_q;
    assign pif.retire_cnt = retire_q;

endmodule
